// File: rtl/pulse_pkg.sv
// Shared constants, FSM state type and fp32 field layout for the pulse playout block.
package pulse_pkg;

  localparam int DEPTH_DEFAULT = 2048;
  localparam int ADDR_STEP     = 4;

  localparam int FP_BIAS  = 127;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LATCH = 3'd2,
    S_CLEAR = 3'd3,
    S_OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/fp32_to_ufix.sv
// Combinational fp32 -> unsigned fixed-point conversion: floor(x * 2^(DAC_W-2)), saturating.
// Negative, zero, denormal and NaN inputs map to 0; +Inf and overflow map to all-ones.
module fp32_to_ufix
  import pulse_pkg::*;
#(
  parameter int DAC_W = 16
) (
  input  logic [31:0]      fp,
  output logic [DAC_W-1:0] sample
);

  localparam int SIG_W = FP_MAN_W + 1;

  logic                sign;
  logic [FP_EXP_W-1:0] expo;
  logic [FP_MAN_W-1:0] man;
  logic [SIG_W-1:0]    sig;
  int                  sh;

  assign {sign, expo, man} = fp;
  assign sig = {1'b1, man};

  // sh is the left shift applied to the 24-bit significand to land on the output LSB
  always_comb begin
    sample = '0;
    sh     = int'(expo) - FP_BIAS + DAC_W - 2 - FP_MAN_W;
    if (sign || expo == '0) begin
      sample = '0;
    end else if (expo == '1) begin
      sample = (man == '0) ? '1 : '0;
    end else if (sh > DAC_W - SIG_W) begin
      sample = '1;
    end else if (sh >= 0) begin
      sample = DAC_W'({{DAC_W{1'b0}}, sig} << sh);
    end else if (sh > -SIG_W) begin
      sample = DAC_W'({{DAC_W{1'b0}}, sig} >> (-sh));
    end else begin
      sample = '0;
    end
  end

endmodule

// File: rtl/pulse_playout.sv
// Scans a pulse BRAM word by word, converts each fp32 amplitude and streams it out on a
// valid/ready sample port. PULSE_PLAYOUT_CLEAR_EN adds a CLEAR state that zeroes each word after reading.
module pulse_playout
  import pulse_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int DAC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic [31:0]      bram_addr,
  output logic [31:0]      bram_data_in,
  output logic             bram_we,
  output logic             bram_ena,
  input  logic [31:0]      bram_data_out,
  output logic [DAC_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             frame_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           state;
  logic [IDX_W-1:0] index;
  logic [IDX_W-1:0] next_index;
  logic [DAC_W-1:0] conv_sample;
  logic             xfer;

  fp32_to_ufix #(.DAC_W(DAC_W)) u_conv (
    .fp     (bram_data_out),
    .sample (conv_sample)
  );

  assign xfer         = (state == S_OUT) && sample_ready;
  assign next_index   = (index == LAST_IDX) ? '0 : index + 1'b1;
  assign frame_done   = xfer && (index == LAST_IDX);
  assign bram_data_in = '0;

`ifdef PULSE_PLAYOUT_CLEAR_EN
  logic we_q;
  assign bram_we = we_q;
`else
  assign bram_we = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      index        <= '0;
      bram_addr    <= '0;
      bram_ena     <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
`ifdef PULSE_PLAYOUT_CLEAR_EN
      we_q         <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state     <= S_READ;
            bram_ena  <= 1'b1;
            bram_addr <= 32'(index) * ADDR_STEP;
          end
        end
        S_READ: begin
          state    <= S_LATCH;
          bram_ena <= 1'b0;
        end
        S_LATCH: begin
          sample_data <= conv_sample;
`ifdef PULSE_PLAYOUT_CLEAR_EN
          state       <= S_CLEAR;
          bram_ena    <= 1'b1;
          we_q        <= 1'b1;
`else
          state        <= S_OUT;
          sample_valid <= 1'b1;
`endif
        end
`ifdef PULSE_PLAYOUT_CLEAR_EN
        S_CLEAR: begin
          state        <= S_OUT;
          bram_ena     <= 1'b0;
          we_q         <= 1'b0;
          sample_valid <= 1'b1;
        end
`endif
        S_OUT: begin
          // Hold the sample and keep the BRAM idle until the consumer accepts it
          if (sample_ready) begin
            sample_valid <= 1'b0;
            index        <= next_index;
            if (enable) begin
              state     <= S_READ;
              bram_ena  <= 1'b1;
              bram_addr <= 32'(next_index) * ADDR_STEP;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_playout.sv
// Directed self-checking bench for pulse_playout with a behavioural BRAM (read-first, 1-cycle latency).
module tb_pulse_playout;

  localparam int DEPTH = 2048;
  localparam int CAP   = 8192;
`ifdef PULSE_PLAYOUT_CLEAR_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_ready = 1'b1;
  logic [31:0] bram_addr;
  logic [31:0] bram_data_in;
  logic        bram_we;
  logic        bram_ena;
  logic [31:0] bram_data_out = '0;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        frame_done;
  logic        init_req = 1'b0;

  logic [31:0] mem [0:DEPTH-1];
  logic [15:0] cap [0:CAP-1];
  int          cap_cyc [0:CAP-1];
  int          n_cap = 0;
  int          frame_cnt = 0;
  int          last_frame_n = 0;
  int          bad_fd = 0;
  int          cyc = 0;

  int tests = 0;
  int fails = 0;

  pulse_playout #(.DEPTH(DEPTH), .DAC_W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .bram_addr     (bram_addr),
    .bram_data_in  (bram_data_in),
    .bram_we       (bram_we),
    .bram_ena      (bram_ena),
    .bram_data_out (bram_data_out),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    case (i)
      0:  pat = 32'h3F800000;
      1:  pat = 32'h3F000000;
      2:  pat = 32'h40000000;
      3:  pat = 32'h3E800000;
      4:  pat = 32'h3E000000;
      5:  pat = 32'h40800000;
      6:  pat = 32'hBF800000;
      7:  pat = 32'h7FC00000;
      8:  pat = 32'h7F800000;
      9:  pat = 32'h80000000;
      10: pat = 32'h3FFFFFFF;
      11: pat = 32'h407FFFFF;
      12: pat = 32'h38800000;
      13: pat = 32'h00000001;
      default: pat = 32'h3F800000 | 32'(i);
    endcase
  endfunction

  // Hand-derived expected samples for DAC_W=16 (scale 2^14)
  function automatic logic [15:0] exp_sample(input int i);
    case (i)
      0:  exp_sample = 16'h4000;
      1:  exp_sample = 16'h2000;
      2:  exp_sample = 16'h8000;
      3:  exp_sample = 16'h1000;
      4:  exp_sample = 16'h0800;
      5:  exp_sample = 16'hFFFF;
      6:  exp_sample = 16'h0000;
      7:  exp_sample = 16'h0000;
      8:  exp_sample = 16'hFFFF;
      9:  exp_sample = 16'h0000;
      10: exp_sample = 16'h7FFF;
      11: exp_sample = 16'hFFFF;
      12: exp_sample = 16'h0001;
      13: exp_sample = 16'h0000;
      default: exp_sample = 16'h4000 + 16'(i / 512);
    endcase
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
    end else if (bram_ena) begin
      if (bram_we) mem[bram_addr[12:2]] <= bram_data_in;
      bram_data_out <= mem[bram_addr[12:2]];
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_done && !(sample_valid && sample_ready)) bad_fd <= bad_fd + 1;
    if (sample_valid && sample_ready) begin
      if (n_cap < CAP) begin
        cap[n_cap]     <= sample_data;
        cap_cyc[n_cap] <= cyc;
      end
      n_cap <= n_cap + 1;
      if (frame_done) begin
        frame_cnt    <= frame_cnt + 1;
        last_frame_n <= n_cap + 1;
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_cap(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (n_cap >= target) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (n_cap >= target) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++; if (bram_addr !== 32'd0) begin fails++; $display("FAIL reset_addr got %h want 0", bram_addr); end
    tests++; if (bram_data_in !== 32'd0) begin fails++; $display("FAIL reset_data_in got %h want 0", bram_data_in); end
    tests++; if (bram_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", bram_we); end
    tests++; if (bram_ena !== 1'b0) begin fails++; $display("FAIL reset_ena got %b want 0", bram_ena); end
    tests++; if (sample_data !== 16'd0) begin fails++; $display("FAIL reset_sample got %h want 0", sample_data); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
  endtask

  task automatic test_latency();
    int k;
    logic ena1;
    logic [31:0] addr1;
    logic we_clr;
    do_reset();
    sample_ready = 1'b1;
    @(posedge clk); #1 enable = 1'b1;
    k = 0; ena1 = 1'b0; addr1 = '1; we_clr = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin ena1 = bram_ena; addr1 = bram_addr; end
      if (j == 3) we_clr = bram_we & bram_ena;
      if (sample_valid) begin k = j; break; end
    end
    tests++; if (ena1 !== 1'b1 || addr1 !== 32'd0) begin fails++; $display("FAIL read_phase got ena=%b addr=%h want ena=1 addr=0", ena1, addr1); end
    tests++; if (k != LAT) begin fails++; $display("FAIL latency got %0d want %0d", k, LAT); end
    tests++; if (sample_data !== 16'h4000) begin fails++; $display("FAIL first_sample got %h want 4000", sample_data); end
`ifdef PULSE_PLAYOUT_CLEAR_EN
    tests++; if (we_clr !== 1'b1) begin fails++; $display("FAIL clear_phase got we&ena=%b want 1", we_clr); end
`else
    tests++; if (we_clr !== 1'b0) begin fails++; $display("FAIL no_clear got we&ena=%b want 0", we_clr); end
`endif
  endtask

  task automatic test_frame();
    bit ok;
    int bad;
    ok = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      if (frame_cnt >= 1) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL frame1_timeout got frames=%0d want 1", frame_cnt); end
    tests++; if (last_frame_n != DEPTH) begin fails++; $display("FAIL frame_len got %0d want %0d", last_frame_n, DEPTH); end
    for (int i = 0; i < 14; i++) begin
      tests++;
      if (cap[i] !== exp_sample(i)) begin fails++; $display("FAIL word%0d got %h want %h", i, cap[i], exp_sample(i)); end
    end
    tests++; if (cap[1000] !== exp_sample(1000)) begin fails++; $display("FAIL word1000 got %h want %h", cap[1000], exp_sample(1000)); end
    tests++; if (cap[2047] !== exp_sample(2047)) begin fails++; $display("FAIL word2047 got %h want %h", cap[2047], exp_sample(2047)); end
    tests++; if (cap_cyc[1] - cap_cyc[0] != LAT) begin fails++; $display("FAIL throughput got %0d want %0d", cap_cyc[1] - cap_cyc[0], LAT); end
`ifdef PULSE_PLAYOUT_CLEAR_EN
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'd0) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL mem_cleared got %0d nonzero words want 0", bad); end
`endif
    ok = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      if (frame_cnt >= 2) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL frame2_timeout got frames=%0d want 2", frame_cnt); end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef PULSE_PLAYOUT_CLEAR_EN
      if (cap[DEPTH + i] !== 16'd0) bad++;
`else
      if (cap[DEPTH + i] !== cap[i]) bad++;
`endif
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL frame2_content got %0d bad samples want 0", bad); end
    enable = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    tests++; if (n_cap != 2 * DEPTH + 1) begin fails++; $display("FAIL stop_count got %0d want %0d", n_cap, 2 * DEPTH + 1); end
    tests++; if (sample_valid !== 1'b0 || bram_ena !== 1'b0) begin fails++; $display("FAIL stop_idle got valid=%b ena=%b want 0 0", sample_valid, bram_ena); end
    tests++; if (bad_fd != 0) begin fails++; $display("FAIL spurious_frame_done got %0d want 0", bad_fd); end
  endtask

  task automatic test_stall();
    int base;
    int bad;
    bit ok;
    do_reset();
    sample_ready = 1'b0;
    enable = 1'b1;
    base = n_cap;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (sample_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL stall_timeout got valid=%b want 1", sample_valid); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (sample_valid !== 1'b1 || sample_data !== 16'h4000 || bram_ena !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    tests++; if (n_cap != base) begin fails++; $display("FAIL stall_no_xfer got %0d want %0d", n_cap - base, 0); end
    enable = 1'b0;
    sample_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if (n_cap != base + 1 || cap[base] !== 16'h4000) begin fails++; $display("FAIL stall_release got n=%0d data=%h want 1 4000", n_cap - base, cap[base]); end
    tests++; if (sample_valid !== 1'b0) begin fails++; $display("FAIL stall_idle got valid=%b want 0", sample_valid); end
  endtask

  task automatic test_enable_drop();
    int base;
    bit ok;
    logic [31:0] addr_seen;
    do_reset();
    sample_ready = 1'b1;
    base = n_cap;
    enable = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bram_ena && !bram_we && bram_addr == 32'd12) begin ok = 1'b1; break; end
    end
    tests++; if (!ok) begin fails++; $display("FAIL drop_read3_timeout got addr=%h want 0000000c", bram_addr); end
    enable = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    tests++; if (n_cap != base + 4 || cap[base + 3] !== 16'h1000) begin fails++; $display("FAIL drop_word3 got n=%0d data=%h want 4 1000", n_cap - base, cap[base + 3]); end
    tests++; if (sample_valid !== 1'b0 || bram_ena !== 1'b0) begin fails++; $display("FAIL drop_idle got valid=%b ena=%b want 0 0", sample_valid, bram_ena); end
    enable = 1'b1;
    addr_seen = '1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bram_ena) begin addr_seen = bram_addr; break; end
    end
    tests++; if (addr_seen !== 32'd16) begin fails++; $display("FAIL resume_addr got %h want 00000010", addr_seen); end
    wait_cap(base + 5, 10, ok);
    tests++; if (!ok || cap[base + 4] !== 16'h0800) begin fails++; $display("FAIL resume_word4 got ok=%b data=%h want 1 0800", ok, cap[base + 4]); end
    enable = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    logic [31:0] addr_seen;
    do_reset();
    sample_ready = 1'b1;
    base = n_cap;
    enable = 1'b1;
    wait_cap(base + 2, 20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mid_timeout got n=%0d want 2", n_cap - base); end
    @(posedge clk); #1;
    tests++; if (bram_ena !== 1'b0 || bram_addr !== 32'd8 || sample_data !== 16'h2000) begin fails++; $display("FAIL mid_latch got ena=%b addr=%h data=%h want 0 00000008 2000", bram_ena, bram_addr, sample_data); end
    rst_n = 1'b0;
    #1;
    tests++; if (bram_addr !== 32'd0 || bram_ena !== 1'b0 || bram_we !== 1'b0) begin fails++; $display("FAIL mid_reset_bram got addr=%h ena=%b we=%b want 0 0 0", bram_addr, bram_ena, bram_we); end
    tests++; if (sample_data !== 16'd0 || sample_valid !== 1'b0 || frame_done !== 1'b0) begin fails++; $display("FAIL mid_reset_sample got data=%h valid=%b fd=%b want 0 0 0", sample_data, sample_valid, frame_done); end
    repeat (3) @(posedge clk);
    #1;
`ifdef PULSE_PLAYOUT_CLEAR_EN
    tests++; if (mem[2] !== 32'h40000000) begin fails++; $display("FAIL mid_no_clear got %h want 40000000", mem[2]); end
`endif
    enable = 1'b0;
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    rst_n = 1'b1;
    base = n_cap;
    @(posedge clk); #1;
    enable = 1'b1;
    addr_seen = '1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (bram_ena) begin addr_seen = bram_addr; break; end
    end
    tests++; if (addr_seen !== 32'd0) begin fails++; $display("FAIL restart_addr got %h want 0", addr_seen); end
    wait_cap(base + 1, 10, ok);
    tests++; if (!ok || cap[base] !== 16'h4000) begin fails++; $display("FAIL restart_word0 got ok=%b data=%h want 1 4000", ok, cap[base]); end
    enable = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_frame();
    test_stall();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
